// File: rtl/aes_req_arbiter.sv
// ---------------------------------------------------------------------------
// aes_req_arbiter
//
// Shares one AES core between two requesters. A request is granted
// round-robin, its plaintext and key are captured and presented to the core,
// and the core result (or a timeout error if the core never reports busy)
// is returned to the owning requester only. Arbitration is non-preemptive:
// no new grant happens until the current response has been consumed.
//
// Ports
//   clk, reset           clock, synchronous active-high reset
//   reqN_valid/data/key  request from requester N (N = 0, 1)
//   reqN_ready           request accepted this cycle (combinational)
//   respN_valid/data/err result for requester N; err marks a core timeout
//   respN_ready          requester N consumes its response
//   core_start           one-cycle start pulse to the shared core
//   core_data/core_key   captured plaintext/key, stable for the whole job
//   core_busy            core is processing
//   core_result          core output, valid once core_busy falls
//   op_count             completed non-error operations (16-bit, wraps)
//
// Parameters
//   WIDTH      data/key/ciphertext width
//   BUSY_WAIT  cycles allowed between core_start and core_busy rising
//              before the job is failed with a timeout (must be >= 1)
// ---------------------------------------------------------------------------
module aes_req_arbiter #(
    parameter int WIDTH     = 128,
    parameter int BUSY_WAIT = 8
) (
    input  logic             clk,
    input  logic             reset,

    input  logic             req0_valid,
    input  logic [WIDTH-1:0] req0_data,
    input  logic [WIDTH-1:0] req0_key,
    output logic             req0_ready,

    input  logic             req1_valid,
    input  logic [WIDTH-1:0] req1_data,
    input  logic [WIDTH-1:0] req1_key,
    output logic             req1_ready,

    output logic             resp0_valid,
    output logic [WIDTH-1:0] resp0_data,
    output logic             resp0_err,
    input  logic             resp0_ready,

    output logic             resp1_valid,
    output logic [WIDTH-1:0] resp1_data,
    output logic             resp1_err,
    input  logic             resp1_ready,

    output logic             core_start,
    output logic [WIDTH-1:0] core_data,
    output logic [WIDTH-1:0] core_key,
    input  logic             core_busy,
    input  logic [WIDTH-1:0] core_result,

    output logic [15:0]      op_count
);

    localparam int CW = (BUSY_WAIT > 1) ? $clog2(BUSY_WAIT + 1) : 1;
    localparam logic [CW-1:0] WAIT_LAST = CW'(BUSY_WAIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        LAUNCH,
        WAIT_BUSY,
        RUN,
        RESP
    } state_t;

    state_t        state;
    logic          owner;       // requester that owns the job in flight
    logic          last_grant;  // requester served most recently
    logic          err_flag;    // current job ended in a timeout
    logic [CW-1:0] wait_cnt;

    logic grant_any;
    logic grant_id;
    logic resp_take;

    // Grant decision. A busy core in IDLE (e.g. still finishing a job that
    // was abandoned by reset) blocks all grants until it goes quiet.
    always_comb begin
        grant_any = 1'b0;
        grant_id  = 1'b0;
        if (!reset && state == IDLE && !core_busy) begin
            if (req0_valid && req1_valid) begin
                grant_any = 1'b1;
                grant_id  = ~last_grant;
            end else if (req0_valid) begin
                grant_any = 1'b1;
                grant_id  = 1'b0;
            end else if (req1_valid) begin
                grant_any = 1'b1;
                grant_id  = 1'b1;
            end
        end
    end

    assign req0_ready = grant_any & ~grant_id;
    assign req1_ready = grant_any &  grant_id;

    assign resp_take = owner ? resp1_ready : resp0_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            owner       <= 1'b0;
            last_grant  <= 1'b1;
            err_flag    <= 1'b0;
            wait_cnt    <= '0;
            core_start  <= 1'b0;
            core_data   <= '0;
            core_key    <= '0;
            resp0_valid <= 1'b0;
            resp0_err   <= 1'b0;
            resp0_data  <= '0;
            resp1_valid <= 1'b0;
            resp1_err   <= 1'b0;
            resp1_data  <= '0;
            op_count    <= '0;
        end else begin
            core_start <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_any) begin
                        core_data  <= grant_id ? req1_data : req0_data;
                        core_key   <= grant_id ? req1_key  : req0_key;
                        owner      <= grant_id;
                        err_flag   <= 1'b0;
                        core_start <= 1'b1;
                        state      <= LAUNCH;
                    end
                end

                LAUNCH: begin
                    wait_cnt <= '0;
                    state    <= WAIT_BUSY;
                end

                WAIT_BUSY: begin
                    if (core_busy) begin
                        state <= RUN;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                        if (wait_cnt == WAIT_LAST) begin
                            // Core never acknowledged: answer the owner with
                            // an error and leave its data register untouched.
                            err_flag <= 1'b1;
                            if (owner) begin
                                resp1_valid <= 1'b1;
                                resp1_err   <= 1'b1;
                            end else begin
                                resp0_valid <= 1'b1;
                                resp0_err   <= 1'b1;
                            end
                            state <= RESP;
                        end
                    end
                end

                RUN: begin
                    if (!core_busy) begin
                        if (owner) begin
                            resp1_data  <= core_result;
                            resp1_valid <= 1'b1;
                            resp1_err   <= 1'b0;
                        end else begin
                            resp0_data  <= core_result;
                            resp0_valid <= 1'b1;
                            resp0_err   <= 1'b0;
                        end
                        state <= RESP;
                    end
                end

                RESP: begin
                    if (resp_take) begin
                        resp0_valid <= 1'b0;
                        resp0_err   <= 1'b0;
                        resp1_valid <= 1'b0;
                        resp1_err   <= 1'b0;
                        if (!err_flag) begin
                            op_count <= op_count + 16'd1;
                        end
                        last_grant <= owner;
                        state      <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_req_arbiter.sv
// ---------------------------------------------------------------------------
// tb_aes_req_arbiter
//
// Self-checking bench for aes_req_arbiter. A behavioural core model answers
// core_start after a chosen busy duration (0 = never answers). A
// transaction-level reference model predicts every output each cycle from
// the arbitration rules and the grant-to-response latency; directed
// scenarios pin the model with literal expectations, then random traffic
// runs against it.
// ---------------------------------------------------------------------------
module tb_aes_req_arbiter;

    localparam int WIDTH     = 128;
    localparam int BUSY_WAIT = 8;

    localparam logic [127:0] PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         req0_valid = 1'b0, req1_valid = 1'b0;
    logic [127:0] req0_data = '0, req0_key = '0, req1_data = '0, req1_key = '0;
    logic         req0_ready, req1_ready;
    logic         resp0_valid, resp1_valid, resp0_err, resp1_err;
    logic [127:0] resp0_data, resp1_data;
    logic         resp0_ready = 1'b1, resp1_ready = 1'b1;
    logic         core_start;
    logic [127:0] core_data, core_key;
    logic         core_busy;
    logic [127:0] core_result = '0;
    logic [15:0]  op_count;

    always #5 clk = ~clk;

    aes_req_arbiter #(.WIDTH(WIDTH), .BUSY_WAIT(BUSY_WAIT)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_data(req0_data), .req0_key(req0_key), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_data(req1_data), .req1_key(req1_key), .req1_ready(req1_ready),
        .resp0_valid(resp0_valid), .resp0_data(resp0_data), .resp0_err(resp0_err), .resp0_ready(resp0_ready),
        .resp1_valid(resp1_valid), .resp1_data(resp1_data), .resp1_err(resp1_err), .resp1_ready(resp1_ready),
        .core_start(core_start), .core_data(core_data), .core_key(core_key),
        .core_busy(core_busy), .core_result(core_result), .op_count(op_count)
    );

    int n_pass = 0;
    int n_total = 0;
    int cyc = 0;
    logic chk_en = 1'b0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Stand-in for the AES core: the known FIPS-197 vector, anything else a
    // cheap keyed scramble.
    function automatic logic [127:0] core_fn(input logic [127:0] d, input logic [127:0] k);
        if (d == PT && k == KEY) return CT;
        return {d[63:0], d[127:64]} ^ k ^ 128'ha5a5_5a5a_0f0f_f0f0_3c3c_c3c3_9696_6969;
    endfunction

    // ---------------- core model (has no reset of its own here) -----------
    int unsigned  cur_d = 1;       // busy duration for the next grant
    int unsigned  core_d_lat = 0;  // duration latched at grant
    int unsigned  core_left = 0;
    logic         start_pend = 1'b0;
    logic [127:0] start_d = '0, start_k = '0;
    logic         force_busy = 1'b0;

    assign core_busy = (core_left != 0) || force_busy;

    always @(negedge clk) begin
        if (core_start === 1'b1) begin
            start_pend = 1'b1;
            start_d    = core_data;
            start_k    = core_key;
        end
    end

    always @(posedge clk) begin
        #1;
        if (core_left > 0) core_left--;
        if (start_pend) begin
            start_pend = 1'b0;
            if (core_d_lat > 0) begin
                core_left   = core_d_lat;
                core_result = core_fn(start_d, start_k);
            end
        end
    end

    // ---------------- reference model state --------------------------------
    int           m_phase = 0;     // 0 free, 1 job in flight, 2 responding
    logic         m_owner = 1'b0;
    logic         m_err = 1'b0;
    logic         m_last = 1'b1;
    logic [15:0]  m_opc = '0;
    logic [127:0] m_cd = '0, m_ck = '0;
    logic [127:0] m_rd [2] = '{'0, '0};
    logic         m_start = 1'b0;
    int           m_cnt = 0;

    // observations used by the directed scenarios
    int   n_grant [2] = '{0, 0};
    int   grant_cyc [2] = '{0, 0};
    int   resp_cyc [2] = '{0, 0};
    int   rs [2] = '{0, 0};
    logic last_err [2] = '{1'b0, 1'b0};
    int   resp_seen = 0;
    int   start_cnt = 0;
    logic prev_rv0 = 1'b0, prev_rv1 = 1'b0;
    int   grant_log [$];

    always @(negedge clk) begin
        logic e_rdy0, e_rdy1;
        cyc++;
        e_rdy0 = 1'b0;
        e_rdy1 = 1'b0;
        if (m_phase == 0 && !reset && !core_busy) begin
            if (req0_valid && req1_valid) begin
                // tie goes to whoever was not served last
                e_rdy0 = (m_last == 1'b1);
                e_rdy1 = (m_last == 1'b0);
            end else begin
                e_rdy0 = req0_valid;
                e_rdy1 = req1_valid;
            end
        end

        if (chk_en) begin
            check("req0_ready", req0_ready, e_rdy0);
            check("req1_ready", req1_ready, e_rdy1);
            check("core_start", core_start, m_start);
            check("core_data", core_data, m_cd);
            check("core_key", core_key, m_ck);
            check("resp0_valid", resp0_valid, m_phase == 2 && m_owner == 1'b0);
            check("resp1_valid", resp1_valid, m_phase == 2 && m_owner == 1'b1);
            if (m_phase == 2 && m_owner == 1'b0) check("resp0_err", resp0_err, m_err);
            if (m_phase == 2 && m_owner == 1'b1) check("resp1_err", resp1_err, m_err);
            check("resp0_data", resp0_data, m_rd[0]);
            check("resp1_data", resp1_data, m_rd[1]);
            check("op_count", op_count, m_opc);

            if (req0_ready && req0_valid) begin n_grant[0]++; grant_cyc[0] = cyc; grant_log.push_back(0); end
            if (req1_ready && req1_valid) begin n_grant[1]++; grant_cyc[1] = cyc; grant_log.push_back(1); end
            if (core_start) start_cnt++;
            if (resp0_valid && !prev_rv0) begin rs[0]++; resp_seen++; resp_cyc[0] = cyc; last_err[0] = resp0_err; end
            if (resp1_valid && !prev_rv1) begin rs[1]++; resp_seen++; resp_cyc[1] = cyc; last_err[1] = resp1_err; end
        end
        prev_rv0 = resp0_valid;
        prev_rv1 = resp1_valid;

        if (reset) begin
            m_phase = 0; m_owner = 1'b0; m_err = 1'b0; m_last = 1'b1; m_opc = '0;
            m_cd = '0; m_ck = '0; m_rd[0] = '0; m_rd[1] = '0; m_start = 1'b0;
        end else begin
            m_start = 1'b0;
            case (m_phase)
                0: if ((e_rdy0 && req0_valid) || (e_rdy1 && req1_valid)) begin
                    m_owner    = e_rdy1 && req1_valid;
                    m_cd       = m_owner ? req1_data : req0_data;
                    m_ck       = m_owner ? req1_key : req0_key;
                    m_start    = 1'b1;
                    core_d_lat = cur_d;
                    m_err      = (cur_d == 0);
                    // grant->response: busy+3, or BUSY_WAIT+2 on timeout
                    m_cnt      = m_err ? BUSY_WAIT + 1 : int'(cur_d) + 2;
                    m_phase    = 1;
                end
                1: begin
                    m_cnt--;
                    if (m_cnt == 0) begin
                        m_phase = 2;
                        if (!m_err) m_rd[m_owner] = core_fn(m_cd, m_ck);
                    end
                end
                default: if (m_owner ? resp1_ready : resp0_ready) begin
                    m_phase = 0;
                    if (!m_err) m_opc = m_opc + 16'd1;
                    m_last = m_owner;
                end
            endcase
        end
    end

    // ---------------- stimulus helpers --------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int n, input logic v, input logic [127:0] d, input logic [127:0] k);
        if (n == 0) begin req0_valid = v; req0_data = d; req0_key = k; end
        else        begin req1_valid = v; req1_data = d; req1_key = k; end
    endtask

    task automatic send(input int n, input logic [127:0] d, input logic [127:0] k, input int unsigned dur);
        int g, w;
        g = n_grant[n];
        cur_d = dur;
        set_req(n, 1'b1, d, k);
        w = 0;
        while (n_grant[n] == g && w < 300) begin tick(); w++; end
        if (n_grant[n] == g) check("send_grant_timeout", 0, 1);
        set_req(n, 1'b0, d, k);
    endtask

    task automatic wait_resp(input int target);
        int w;
        w = 0;
        while (resp_seen < target && w < 300) begin tick(); w++; end
        if (resp_seen < target) check("resp_wait_timeout", resp_seen, target);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int s, g, qs, r0, r1, k0, k1, w;
        logic [127:0] d, k;

        tick();
        chk_en = 1'b1;
        tick();
        check("reset_op_count", op_count, 16'h0000);
        check("reset_resp0_valid", resp0_valid, 1'b0);
        check("reset_core_start", core_start, 1'b0);
        check("reset_core_data", core_data, 128'h0);
        tick();
        reset = 1'b0;
        tick();

        // single request with the known AES vector, 40-cycle core
        s = start_cnt;
        send(0, PT, KEY, 40);
        wait_resp(resp_seen + 1);
        check("t_single_latency", resp_cyc[0] - grant_cyc[0], 43);
        check("t_single_data", resp0_data, CT);
        check("t_single_err", last_err[0], 1'b0);
        check("t_single_op_count", op_count, 16'd1);
        check("t_single_starts", start_cnt - s, 1);
        check("t_single_resp1", rs[1], 0);

        // timeout: core never goes busy, then a normal request
        send(1, rnd128(), rnd128(), 0);
        wait_resp(resp_seen + 1);
        check("t_timeout_latency", resp_cyc[1] - grant_cyc[1], BUSY_WAIT + 2);
        check("t_timeout_err", last_err[1], 1'b1);
        check("t_timeout_op_count", op_count, 16'd1);
        send(0, rnd128(), rnd128(), 5);
        wait_resp(resp_seen + 1);
        check("t_after_timeout_err", last_err[0], 1'b0);
        check("t_after_timeout_op_count", op_count, 16'd2);

        // response backpressure on requester 1 blocks requester 0
        resp1_ready = 1'b0;
        send(1, rnd128(), rnd128(), 6);
        wait_resp(resp_seen + 1);
        s = start_cnt;
        g = n_grant[0];
        set_req(0, 1'b1, rnd128(), rnd128());
        cur_d = 4;
        repeat (20) tick();
        check("t_bp_no_start", start_cnt - s, 0);
        check("t_bp_no_grant", n_grant[0] - g, 0);
        resp1_ready = 1'b1;
        w = 0;
        while (n_grant[0] == g && w < 50) begin tick(); w++; end
        req0_valid = 1'b0;
        check("t_bp_grant_owner", grant_log[grant_log.size() - 1], 0);
        wait_resp(resp_seen + 1);
        check("t_bp_op_count", op_count, 16'd4);

        // reset while the core is running: job abandoned, no response
        send(0, rnd128(), rnd128(), 30);
        repeat (8) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("t_rst_op_count", op_count, 16'd0);
        check("t_rst_resp0_valid", resp0_valid, 1'b0);
        check("t_rst_core_data", core_data, 128'h0);
        r0 = rs[0];
        repeat (40) tick();
        check("t_rst_no_resp", rs[0] - r0, 0);

        // two back-to-back ties: 0,1,0,1
        qs = grant_log.size();
        r0 = rs[0]; r1 = rs[1];
        s = resp_seen;
        k0 = 0; k1 = 0;
        cur_d = 3;
        set_req(0, 1'b1, rnd128(), rnd128());
        set_req(1, 1'b1, rnd128(), rnd128());
        g = n_grant[0]; w = n_grant[1];
        for (int i = 0; i < 400 && (k0 < 2 || k1 < 2); i++) begin
            tick();
            if (n_grant[0] > g + k0) begin k0++; set_req(0, k0 < 2, rnd128(), rnd128()); end
            if (n_grant[1] > w + k1) begin k1++; set_req(1, k1 < 2, rnd128(), rnd128()); end
        end
        wait_resp(s + 4);
        check("t_tie_count", grant_log.size() - qs, 4);
        if (grant_log.size() >= qs + 4) begin
            check("t_tie_g0", grant_log[qs], 0);
            check("t_tie_g1", grant_log[qs + 1], 1);
            check("t_tie_g2", grant_log[qs + 2], 0);
            check("t_tie_g3", grant_log[qs + 3], 1);
        end
        check("t_tie_resp0", rs[0] - r0, 2);
        check("t_tie_resp1", rs[1] - r1, 2);

        // busy core while idle blocks grants
        force_busy = 1'b1;
        g = n_grant[1];
        set_req(1, 1'b1, rnd128(), rnd128());
        repeat (6) tick();
        check("t_busy_idle_no_grant", n_grant[1] - g, 0);
        force_busy = 1'b0;
        w = 0;
        while (n_grant[1] == g && w < 50) begin tick(); w++; end
        req1_valid = 1'b0;
        check("t_busy_idle_grant", n_grant[1] - g, 1);
        wait_resp(resp_seen + 1);

        // op_count wrap
        force dut.op_count = 16'hffff;
        m_opc = 16'hffff;
        tick();
        release dut.op_count;
        tick();
        send(0, rnd128(), rnd128(), 2);
        wait_resp(resp_seen + 1);
        check("t_wrap_op_count", op_count, 16'h0000);

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            int lg0, lg1;
            lg0 = n_grant[0];
            lg1 = n_grant[1];
            tick();
            cur_d = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 12);
            resp0_ready = ($urandom_range(0, 3) != 0);
            resp1_ready = ($urandom_range(0, 3) != 0);
            for (int n = 0; n < 2; n++) begin
                logic v, acc;
                v   = (n == 0) ? req0_valid : req1_valid;
                acc = (n == 0) ? (n_grant[0] != lg0) : (n_grant[1] != lg1);
                if (v && acc) set_req(n, $urandom_range(0, 1) == 1, rnd128(), rnd128());
                else if (v && $urandom_range(0, 9) == 0) set_req(n, 1'b0, rnd128(), rnd128());
                else if (!v && $urandom_range(0, 2) == 0) set_req(n, 1'b1, rnd128(), rnd128());
            end
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        resp0_ready = 1'b1;
        resp1_ready = 1'b1;
        repeat (40) tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
